// File: rtl/axis_src_tag_mux_if.sv
// AXI-stream bundle shared by the inputs and the output of axis_src_tag_mux.
// LANES sets how many parallel streams the bundle carries. All lanes are
// packed into flat vectors, with lane i at [i*W +: W].
//   tdata/tkeep/tuser : per-lane payload
//   tvalid/tlast      : per-lane handshake and end of packet
//   tready            : per-lane backpressure, driven by the receiver
//   tdest             : per-lane routing tag, driven by the sender
// master drives payload and valid and reads ready. slave is the reverse.
interface axis_src_tag_mux_if #(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1
);
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES*KEEP_WIDTH-1:0] tkeep;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tready;
  logic [LANES-1:0]            tlast;
  logic [LANES*USER_WIDTH-1:0] tuser;
  logic [LANES*DEST_WIDTH-1:0] tdest;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, tdest, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_src_tag_mux.sv
// Packet-level round-robin merge of S_COUNT AXI streams onto one output.
// Each outgoing beat is tagged on tdest with the index of its input, so a
// tdest-decoding switch can route the return path.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   s_axis : S_COUNT input lanes (slave). tready is driven per lane.
//   m_axis : merged output lane (master). It is fed from a 2-entry skid buffer.
//
// state  | meaning
// IDLE   | no grant is held; arbitrate among the requesting inputs
// ACTIVE | input sel is granted until its tlast beat is accepted
module axis_src_tag_mux #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axis_src_tag_mux_if.slave    s_axis,
  axis_src_tag_mux_if.master   m_axis
);

  localparam int SEL_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t             state, state_next;
  logic [SEL_W-1:0]   sel, sel_next;
  logic [SEL_W-1:0]   last_grant, last_grant_next;
  logic [SEL_W-1:0]   rr_pick, hi_pick, lo_pick;
  logic               hi_found, lo_found;
  logic [S_COUNT-1:0] tready_vec;

  logic [DATA_WIDTH-1:0] in_data;
  logic [KEEP_WIDTH-1:0] in_keep;
  logic [USER_WIDTH-1:0] in_user;
  logic [DEST_WIDTH-1:0] in_dest;
  logic                  in_valid, in_last, in_ready, accept;

  logic                  out_valid, skid_valid;
  logic [DATA_WIDTH-1:0] out_data, skid_data;
  logic [KEEP_WIDTH-1:0] out_keep, skid_keep;
  logic [USER_WIDTH-1:0] out_user, skid_user;
  logic [DEST_WIDTH-1:0] out_dest, skid_dest;
  logic                  out_last, skid_last;

  // Select the granted lane. The loop uses constant indices, so sel never
  // forms a variable part-select.
  always_comb begin
    in_data  = '0;
    in_keep  = '0;
    in_user  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (sel == SEL_W'(i)) begin
        in_data  = s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
        in_keep  = s_axis.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        in_user  = s_axis.tuser[i*USER_WIDTH +: USER_WIDTH];
        in_valid = s_axis.tvalid[i];
        in_last  = s_axis.tlast[i];
      end
    end
  end

  assign in_dest  = DEST_WIDTH'(sel);
  // Ready depends only on skid occupancy, so there is no combinational path
  // from m_axis.tready back to s_axis.tready.
  assign in_ready = !skid_valid;
  assign accept   = (state == ACTIVE) && in_valid && in_ready;

  // Round robin. First look for the lowest requester above last_grant. If
  // there is none, wrap to the lowest requester overall. That fallback also
  // covers the case where last_grant is the only input requesting.
  always_comb begin
    hi_pick  = '0;
    lo_pick  = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (!hi_found && s_axis.tvalid[i] && (SEL_W'(i) > last_grant)) begin
        hi_pick  = SEL_W'(i);
        hi_found = 1'b1;
      end
      if (!lo_found && s_axis.tvalid[i]) begin
        lo_pick  = SEL_W'(i);
        lo_found = 1'b1;
      end
    end
    rr_pick = hi_found ? hi_pick : lo_pick;
  end

  always_comb begin
    state_next      = state;
    sel_next        = sel;
    last_grant_next = last_grant;
    tready_vec      = '0;
    case (state)
      IDLE: begin
        if (|s_axis.tvalid) begin
          sel_next        = rr_pick;
          last_grant_next = rr_pick;
          state_next      = ACTIVE;
        end
      end
      ACTIVE: begin
        for (int i = 0; i < S_COUNT; i++) begin
          tready_vec[i] = (sel == SEL_W'(i)) && in_ready;
        end
        if (accept && in_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      last_grant <= SEL_W'(S_COUNT - 1);
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      state      <= state_next;
      sel        <= sel_next;
      last_grant <= last_grant_next;
      if (m_axis.tready || !out_valid) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          out_valid  <= accept;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
      end
    end
  end

  // The payload registers carry no reset. The valid flags above decide
  // whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (m_axis.tready || !out_valid) begin
      if (skid_valid) begin
        out_data <= skid_data;
        out_keep <= skid_keep;
        out_user <= skid_user;
        out_dest <= skid_dest;
        out_last <= skid_last;
      end else if (accept) begin
        out_data <= in_data;
        out_keep <= in_keep;
        out_user <= in_user;
        out_dest <= in_dest;
        out_last <= in_last;
      end
    end else if (accept) begin
      skid_data <= in_data;
      skid_keep <= in_keep;
      skid_user <= in_user;
      skid_dest <= in_dest;
      skid_last <= in_last;
    end
  end

  assign s_axis.tready = tready_vec;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tkeep  = out_keep;
  assign m_axis.tuser  = out_user;
  assign m_axis.tlast  = out_last;
  assign m_axis.tdest  = out_dest;

endmodule

// File: tb/tb_axis_src_tag_mux.sv
module tb_axis_src_tag_mux;
  localparam int S  = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 1;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_src_tag_mux_if #(.LANES(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEST_WIDTH(TW)) s_bus ();
  axis_src_tag_mux_if #(.LANES(1), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEST_WIDTH(TW)) m_bus ();
  assign s_bus.tdest = '0;

  axis_src_tag_mux #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEST_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_bus), .m_axis(m_bus));

  typedef struct packed {logic [DW-1:0] data; logic [KW-1:0] keep; logic last; logic [UW-1:0] user;} beat_t;
  typedef struct {beat_t b; int dest; int cyc;} obs_t;
  typedef struct {int src; int len; int exp_dest; int exp_lat;} vec_t;

  beat_t srcq [S][$];
  beat_t expq [S][$];
  obs_t  outq [$];
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [S-1:0] en = '1;
  int gap_pct = 0, rdy_mode = 0, pause_len = 5;
  int pause_at [S] = '{-1, -1, -1, -1};
  int pause_cnt[S] = '{0, 0, 0, 0};
  int acc_cnt  [S] = '{0, 0, 0, 0};
  int first_cyc[S] = '{-1, -1, -1, -1};

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_pkt(input int src, input int len, input int tag);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.data = {8'(src), 8'(tag), 16'(b)};
      bt.keep = 4'(b + src + tag);
      bt.last = (b == len - 1);
      bt.user = 1'(b + tag);
      srcq[src].push_back(bt);
      expq[src].push_back(bt);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < S; i++) begin
      srcq[i].delete();
      expq[i].delete();
    end
    outq.delete();
  endtask

  task automatic wait_out(input string nm, input int n, input int limit);
    int k = 0;
    while (outq.size() < n && k < limit) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    chk({nm, "_count"}, 64'(outq.size()), 64'(n));
  endtask

  // Compares the observed beat idx against the next beat expected from exp_dest.
  task automatic score(input string nm, input int idx, input int exp_dest);
    obs_t o;
    beat_t e;
    if (idx >= outq.size()) begin
      chk({nm, "_present"}, 64'(outq.size()), 64'(idx + 1));
      return;
    end
    o = outq[idx];
    chk({nm, "_dest"}, 64'(o.dest), 64'(exp_dest));
    if (exp_dest < 0 || exp_dest >= S || expq[exp_dest].size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_extra: unexpected beat %0h from input %0d", nm, o.b, o.dest);
      return;
    end
    e = expq[exp_dest].pop_front();
    chk({nm, "_beat"}, 64'(o.b), 64'(e));
  endtask

  // Source/sink engine. It samples at negedge and drives #1 after posedge.
  initial begin : engine
    logic [S-1:0] acc, v, l;
    logic [S*DW-1:0] d;
    logic [S*KW-1:0] k;
    logic [S*UW-1:0] u;
    logic prev_stall, tgl;
    beat_t prev_b, hb;
    obs_t ob;
    int prev_d;
    prev_stall = 1'b0;
    tgl = 1'b0;
    prev_d = 0;
    prev_b = '0;
    s_bus.tvalid = '0; s_bus.tdata = '0; s_bus.tkeep = '0; s_bus.tlast = '0; s_bus.tuser = '0;
    m_bus.tready = 1'b0;
    forever begin
      @(negedge clk);
      acc = s_bus.tvalid & s_bus.tready;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(m_bus.tvalid), 64'd1);
          chk("stall_payload", 64'({m_bus.tdata, m_bus.tkeep, m_bus.tlast, m_bus.tuser}), 64'(prev_b));
          chk("stall_dest", 64'(m_bus.tdest), 64'(prev_d));
        end
        prev_stall = m_bus.tvalid && !m_bus.tready;
        prev_b = '{data: m_bus.tdata, keep: m_bus.tkeep, last: m_bus.tlast, user: m_bus.tuser};
        prev_d = int'(m_bus.tdest);
        if (m_bus.tvalid && m_bus.tready) begin
          ob.b = prev_b;
          ob.dest = prev_d;
          ob.cyc = cyc;
          outq.push_back(ob);
        end
      end
      @(posedge clk);
      #1;
      v = '0; d = '0; k = '0; l = '0; u = '0;
      for (int i = 0; i < S; i++) begin
        if (pause_cnt[i] > 0) pause_cnt[i]--;
        if (acc[i]) begin
          if (srcq[i].size() > 0) hb = srcq[i].pop_front();
          acc_cnt[i]++;
          if (acc_cnt[i] == pause_at[i]) pause_cnt[i] = pause_len;
        end
        if (srcq[i].size() > 0 && en[i] && pause_cnt[i] == 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
          hb = srcq[i][0];
          v[i] = 1'b1;
          d[i*DW +: DW] = hb.data;
          k[i*KW +: KW] = hb.keep;
          l[i] = hb.last;
          u[i*UW +: UW] = hb.user;
          if (first_cyc[i] < 0) first_cyc[i] = cyc;
        end
      end
      s_bus.tvalid = v; s_bus.tdata = d; s_bus.tkeep = k; s_bus.tlast = l; s_bus.tuser = u;
      case (rdy_mode)
        0: m_bus.tready = 1'b1;
        1: begin tgl = ~tgl; m_bus.tready = tgl; end
        2: m_bus.tready = ($urandom_range(0, 3) != 0);
        default: m_bus.tready = 1'b0;
      endcase
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl [6];
    int order [6];
    int pend [S];
    int exp_seq [4];
    int last, rel_cyc, kk, total, open_d, idx;
    string nm;

    tbl[0] = '{src: 2, len: 3, exp_dest: 2, exp_lat: 2};
    tbl[1] = '{src: 0, len: 1, exp_dest: 0, exp_lat: 2};
    tbl[2] = '{src: 3, len: 4, exp_dest: 3, exp_lat: 2};
    tbl[3] = '{src: 1, len: 2, exp_dest: 1, exp_lat: 2};
    tbl[4] = '{src: 2, len: 1, exp_dest: 2, exp_lat: 2};
    tbl[5] = '{src: 3, len: 2, exp_dest: 3, exp_lat: 2};

    // Reset state. A request is already present during reset.
    push_pkt(1, 2, 99);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_bus.tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_bus.tready), 64'd0);
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single-source packets, driven from the table.
    for (int t = 0; t < 6; t++) begin
      nm = $sformatf("tbl%0d", t);
      outq.delete();
      first_cyc[tbl[t].src] = -1;
      push_pkt(tbl[t].src, tbl[t].len, t);
      wait_out(nm, tbl[t].len, 60);
      if (outq.size() > 0) chk({nm, "_latency"}, 64'(outq[0].cyc - first_cyc[tbl[t].src]), 64'(tbl[t].exp_lat));
      for (int b = 0; b < tbl[t].len; b++) begin
        score(nm, b, tbl[t].exp_dest);
        if (b > 0 && b < outq.size()) chk({nm, "_rate"}, 64'(outq[b].cyc - outq[b-1].cyc), 64'd1);
      end
    end

    // Round robin across inputs 0, 1 and 3. All are requesting from reset release.
    rst_n = 1'b0;
    clear_all();
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, 2, 10 + r);
      push_pkt(1, 2, 20 + r);
      push_pkt(3, 2, 30 + r);
    end
    pend = '{2, 2, 0, 2};
    last = S - 1;
    for (int p = 0; p < 6; p++) begin
      order[p] = -1;
      for (int j = 1; j <= S && order[p] < 0; j++) begin
        if (pend[(last + j) % S] > 0) order[p] = (last + j) % S;
      end
      pend[order[p]]--;
      last = order[p];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rel_cyc = cyc;
    rst_n = 1'b1;
    wait_out("rr", 12, 100);
    if (outq.size() > 0) chk("rr_first_grant", 64'(outq[0].cyc - rel_cyc), 64'd2);
    for (int p = 0; p < 6; p++) begin
      score($sformatf("rr_p%0d_b0", p), 2*p, order[p]);
      score($sformatf("rr_p%0d_b1", p), 2*p + 1, order[p]);
      if (p > 0 && 2*p < outq.size()) chk("rr_idle_gap", 64'(outq[2*p].cyc - outq[2*p-1].cyc), 64'd2);
    end

    // Backpressure: tready toggles every cycle across an 8-beat packet.
    outq.delete();
    rdy_mode = 1;
    push_pkt(2, 8, 40);
    wait_out("bp", 8, 100);
    repeat (5) @(posedge clk);
    chk("bp_no_dup", 64'(outq.size()), 64'd8);
    for (int b = 0; b < 8; b++) score($sformatf("bp_b%0d", b), b, 2);
    rdy_mode = 0;

    // Mid-packet gap: input 1 pauses after its 2nd beat while input 0 requests.
    outq.delete();
    acc_cnt[1] = 0;
    pause_at[1] = 2;
    push_pkt(1, 4, 50);
    kk = 0;
    while (outq.size() < 1 && kk < 50) begin @(posedge clk); kk++; end
    push_pkt(0, 2, 51);
    wait_out("gap", 6, 100);
    pause_at[1] = -1;
    for (int b = 0; b < 4; b++) score($sformatf("gap_in1_b%0d", b), b, 1);
    for (int b = 0; b < 2; b++) score($sformatf("gap_in0_b%0d", b), 4 + b, 0);

    // Reset while the skid buffer holds two beats.
    outq.delete();
    rdy_mode = 3;
    acc_cnt[3] = 0;
    push_pkt(3, 6, 60);
    kk = 0;
    while (acc_cnt[3] < 2 && kk < 50) begin @(posedge clk); kk++; end
    @(negedge clk);
    chk("full_m_tvalid", 64'(m_bus.tvalid), 64'd1);
    chk("full_s_tready", 64'(s_bus.tready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_m_tvalid", 64'(m_bus.tvalid), 64'd0);
    chk("async_rst_s_tready", 64'(s_bus.tready), 64'd0);
    clear_all();
    rdy_mode = 0;
    push_pkt(2, 2, 70);
    push_pkt(0, 2, 71);
    exp_seq = '{0, 0, 2, 2};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rel_cyc = cyc;
    rst_n = 1'b1;
    wait_out("rst2", 4, 60);
    if (outq.size() > 0) chk("rst2_first_grant", 64'(outq[0].cyc - rel_cyc), 64'd2);
    for (int b = 0; b < 4; b++) score($sformatf("rst2_b%0d", b), b, exp_seq[b]);

    // Randomized traffic: per-input ordering and packet atomicity.
    outq.delete();
    rdy_mode = 2;
    gap_pct = 30;
    total = 0;
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < S; i++) begin
        kk = int'($urandom_range(1, 6));
        push_pkt(i, kk, 100 + p);
        total += kk;
      end
    end
    wait_out("rand", total, 20000);
    open_d = -1;
    for (int b = 0; b < outq.size(); b++) begin
      idx = outq[b].dest;
      if (open_d >= 0) chk("rand_interleave", 64'(idx), 64'(open_d));
      score("rand", b, idx);
      open_d = outq[b].b.last ? -1 : idx;
    end
    for (int i = 0; i < S; i++) chk($sformatf("rand_left%0d", i), 64'(expq[i].size()), 64'd0);
    gap_pct = 0;
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
